iiitb_vm_change_dispenser: RTL and testbench
============================================

// Module: iiitb_vm_change_dispenser
// PURPOSE
//  Payout end of the vending machine's change interface: consumes the 2-bit
//  change code produced by iiitb_vm and drives the coin-hopper actuators.
//  Queues change requests, pulses the matching hopper and waits for the coin-exit
//  sensor, retries on timeout and flags jams. Sits between iiitb_vm and the board I/O.
// PARAMETERS
//  FIFO_DEPTH      4   pending change requests held (power of 2, >=2)
//  PULSE_CYCLES    8   hopper fire pulse width in clk cycles (>=1)
//  TIMEOUT_CYCLES  64  cycles after pulse end to wait for coin_sense (>=1)
//  MAX_RETRY       2   re-fires after a timeout before declaring a jam
// PORTS
//  clk         in   1  single clock, rising edge
//  rst_n       in   1  asynchronous, active-low reset
//  change      in   2  change code from iiitb_vm: 00 none, 01 one 5-unit, 10 one 10-unit, 11 illegal
//  coin_sense  in   1  coin-exit sensor, synchronous, one-cycle-or-longer high per coin
//  clr_err     in   1  clears jam_err, ovf_err, bad_code; releases JAM state
//  hop5_fire   out  1  5-unit hopper actuator
//  hop10_fire  out  1  10-unit hopper actuator
//  busy        out  1  high when FSM not IDLE or FIFO non-empty
//  fifo_full   out  1  FIFO holds FIFO_DEPTH entries
//  ovf_err     out  1  sticky: request arrived while full (request dropped)
//  bad_code    out  1  sticky: code 11 captured (request dropped)
//  jam_err     out  1  sticky: MAX_RETRY exhausted
//  coins_paid  out  8  count of confirmed coins, wraps 255->0
// BEHAVIOUR
//  - Reset (async, rst_n=0): all outputs 0, FIFO empty, FSM IDLE, counters 0;
//    fire outputs drop immediately, mid-pulse included; in-flight request is lost.
//  - Capture: change registered each cycle (chg_q). Request = change!=00 and chg_q==00
//    (rising from none); a held code gives one request only. Code change 01->10 without
//    passing 00 is not a new request.
//  - Request 01/10: pushed if not full; if full and no pop same cycle -> dropped, ovf_err=1.
//    Push and pop in same cycle while full: push accepted, occupancy unchanged.
//  - Request 11: never pushed, bad_code=1.
//  - FSM states IDLE, FIRE, WAIT, JAM:
//    IDLE: FIFO non-empty -> FIRE next cycle, retry_cnt=0 (head not popped yet).
//    FIRE: hop5_fire or hop10_fire (per head code) high exactly PULSE_CYCLES cycles,
//      then WAIT. coin_sense seen during FIRE counts as confirmation (pulse still
//      completes, then pop + IDLE, no WAIT).
//    WAIT: coin_sense=1 -> pop head, coins_paid+1, IDLE. Timer reaches TIMEOUT_CYCLES:
//      retry_cnt<MAX_RETRY -> retry_cnt+1, FIRE; else jam_err=1, JAM.
//    JAM: no firing, FIFO keeps head and still accepts pushes; clr_err -> IDLE (head retried).
//  - Latency: request edge at cycle N -> fire high from N+2 (capture reg + push) if idle.
//  - coin_sense outside FIRE/WAIT ignored. clr_err has priority over a same-cycle set of
//    any sticky flag (flag ends cleared).
//  - Only one fire output high at any time; fire outputs registered, glitch-free.
// STRUCTURE
//  - Package iiitb_vm_pkg: coin code localparams (CHG_NONE/CHG_5/CHG_10/CHG_BAD), state
//    typedef/encoding, coins_paid width.
//  - Sub-module iiitb_vm_chg_fifo: sync FIFO, 1-bit entries (0=5-unit,1=10-unit), ports
//    push/pop/din/dout/full/empty, same clk/rst_n. Remainder (capture, FSM, timers) in top.
// TESTING
//  1 Reset: rst_n=0 during hop10_fire pulse -> fire 0 same cycle, all outputs 0, busy 0.
//  2 Single payout: change 00->01 held 3 cycles, coin_sense 1 cycle at 10 cycles after
//    pulse -> exactly one 8-cycle hop5_fire pulse, coins_paid=1, busy back to 0.
//  3 Timeout/jam: change 00->10, no coin_sense -> 3 hop10_fire pulses 72 cycles apart,
//    jam_err=1, FSM JAM; clr_err -> one more pulse; then coin_sense -> coins_paid=1.
//  4 Overflow: 5 requests (01,00 alternating) with coin_sense held 0 -> fifo_full=1 after 4,
//    5th dropped, ovf_err=1; later confirms pay out exactly 4 coins in order.
//  5 Illegal/edge: change 00->11 -> bad_code=1, no fire; change 01->10 direct -> one request only.
//  6 Simultaneous: full FIFO, coin_sense pop and new request same cycle -> no ovf_err,
//    fifo_full stays 1, order preserved; coins_paid wrap 255->0 checked with 256 payouts.

Source files
------------

// File: rtl/iiitb_vm_pkg.sv
// Shared definitions for the vending-machine change dispenser.
// Holds the change codes produced by iiitb_vm, the payout FSM state encoding and
// the width of the confirmed-coin counter.
package iiitb_vm_pkg;

  localparam logic [1:0] CHG_NONE = 2'b00;
  localparam logic [1:0] CHG_5    = 2'b01;
  localparam logic [1:0] CHG_10   = 2'b10;
  localparam logic [1:0] CHG_BAD  = 2'b11;

  localparam int unsigned COINS_W = 8;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StFire = 2'b01,
    StWait = 2'b10,
    StJam  = 2'b11
  } state_e;

endpackage

// File: rtl/iiitb_vm_chg_fifo.sv
// Synchronous FIFO of pending change requests, one bit per entry
// (0 = 5-unit coin, 1 = 10-unit coin).
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   push, din   write request and data; ignored when full unless popping
//   pop         remove head; ignored when empty
//   dout        current head entry
//   full, empty occupancy flags
// FIFO_DEPTH must be a power of two so the extra pointer bit wraps cleanly.
module iiitb_vm_chg_fifo #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [FIFO_DEPTH-1:0] mem_q, mem_d;
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic                  push_en, pop_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  assign pop_en  = pop && !empty;
  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign push_en = push && (!full || pop_en);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_en) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/iiitb_vm_change_dispenser.sv
// Change payout controller: turns change codes from iiitb_vm into hopper pulses.
// Ports:
//   clk, rst_n             clock and asynchronous active-low reset
//   change[1:0]            00 none, 01 5-unit, 10 10-unit, 11 illegal
//   coin_sense             coin-exit sensor, high at least one cycle per coin
//   clr_err                clears sticky flags and releases the jam state
//   hop5_fire, hop10_fire  registered hopper actuators, never both high
//   busy                   FSM active or requests pending
//   fifo_full              request queue is full
//   ovf_err, bad_code      sticky: request dropped (queue full / illegal code)
//   jam_err                sticky: retries exhausted without a coin
//   coins_paid             confirmed coin count, wraps
module iiitb_vm_change_dispenser
  import iiitb_vm_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned PULSE_CYCLES   = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned MAX_RETRY      = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         change,
  input  logic               coin_sense,
  input  logic               clr_err,
  output logic               hop5_fire,
  output logic               hop10_fire,
  output logic               busy,
  output logic               fifo_full,
  output logic               ovf_err,
  output logic               bad_code,
  output logic               jam_err,
  output logic [COINS_W-1:0] coins_paid
);

  localparam int unsigned PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [PW-1:0] PULSE_LAST   = PW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRY);

  state_e               state_q, state_d;
  logic [1:0]           chg_q;
  logic [PW-1:0]        pulse_q, pulse_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [RW-1:0]        retry_q, retry_d;
  logic                 seen_q, seen_d;
  logic                 hop5_q, hop5_d;
  logic                 hop10_q, hop10_d;
  logic                 ovf_q, ovf_d;
  logic                 bad_q, bad_d;
  logic                 jam_q, jam_d;
  logic [COINS_W-1:0]   coins_q, coins_d;

  logic req, req_coin, req_bad;
  logic fifo_push, fifo_pop, fifo_dout, fifo_empty, fifo_full_w;
  logic coin_inc, jam_set, ovf_set;

  // A request is the rising edge out of "none"; a code switch without 00 is not new.
  assign req      = (change != CHG_NONE) && (chg_q == CHG_NONE);
  assign req_coin = req && ((change == CHG_5) || (change == CHG_10));
  assign req_bad  = req && (change == CHG_BAD);

  assign fifo_push = req_coin && (!fifo_full_w || fifo_pop);
  assign ovf_set   = req_coin && fifo_full_w && !fifo_pop;

  iiitb_vm_chg_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (fifo_push),
    .pop  (fifo_pop),
    .din  (change == CHG_10),
    .dout (fifo_dout),
    .full (fifo_full_w),
    .empty(fifo_empty)
  );

  // State register (all flops, including registered outputs).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      chg_q   <= CHG_NONE;
      pulse_q <= '0;
      timer_q <= '0;
      retry_q <= '0;
      seen_q  <= 1'b0;
      hop5_q  <= 1'b0;
      hop10_q <= 1'b0;
      ovf_q   <= 1'b0;
      bad_q   <= 1'b0;
      jam_q   <= 1'b0;
      coins_q <= '0;
    end else begin
      state_q <= state_d;
      chg_q   <= change;
      pulse_q <= pulse_d;
      timer_q <= timer_d;
      retry_q <= retry_d;
      seen_q  <= seen_d;
      hop5_q  <= hop5_d;
      hop10_q <= hop10_d;
      ovf_q   <= ovf_d;
      bad_q   <= bad_d;
      jam_q   <= jam_d;
      coins_q <= coins_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    pulse_d  = pulse_q;
    timer_d  = timer_q;
    retry_d  = retry_q;
    seen_d   = seen_q;
    fifo_pop = 1'b0;
    coin_inc = 1'b0;
    jam_set  = 1'b0;
    case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          state_d = StFire;
          pulse_d = '0;
          retry_d = '0;
          seen_d  = 1'b0;
        end
      end
      StFire: begin
        if (coin_sense) seen_d = 1'b1;
        if (pulse_q == PULSE_LAST) begin
          // A coin seen while firing confirms the payout without waiting.
          if (seen_q || coin_sense) begin
            fifo_pop = 1'b1;
            coin_inc = 1'b1;
            state_d  = StIdle;
          end else begin
            state_d = StWait;
            timer_d = '0;
          end
        end else begin
          pulse_d = pulse_q + 1'b1;
        end
      end
      StWait: begin
        if (coin_sense) begin
          fifo_pop = 1'b1;
          coin_inc = 1'b1;
          state_d  = StIdle;
        end else if (timer_q == TIMEOUT_LAST) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 1'b1;
            state_d = StFire;
            pulse_d = '0;
            seen_d  = 1'b0;
          end else begin
            jam_set = 1'b1;
            state_d = StJam;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StJam: begin
        if (clr_err) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic: next values of the registered outputs and flags.
  always_comb begin
    hop5_d  = (state_d == StFire) && !fifo_dout;
    hop10_d = (state_d == StFire) && fifo_dout;
    coins_d = coins_q + COINS_W'(coin_inc);
    // Clear wins over a same-cycle set.
    ovf_d   = clr_err ? 1'b0 : (ovf_q | ovf_set);
    bad_d   = clr_err ? 1'b0 : (bad_q | req_bad);
    jam_d   = clr_err ? 1'b0 : (jam_q | jam_set);
  end

  assign hop5_fire  = hop5_q;
  assign hop10_fire = hop10_q;
  assign busy       = (state_q != StIdle) || !fifo_empty;
  assign fifo_full  = fifo_full_w;
  assign ovf_err    = ovf_q;
  assign bad_code   = bad_q;
  assign jam_err    = jam_q;
  assign coins_paid = coins_q;

endmodule

// File: tb/tb_iiitb_vm_change_dispenser.sv
module tb_iiitb_vm_change_dispenser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] change = 2'b00;
  logic       coin_sense = 1'b0;
  logic       clr_err = 1'b0;
  logic       hop5_fire, hop10_fire, busy, fifo_full, ovf_err, bad_code, jam_err;
  logic [7:0] coins_paid;

  int checks = 0;
  int failures = 0;

  iiitb_vm_change_dispenser dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .change    (change),
    .coin_sense(coin_sense),
    .clr_err   (clr_err),
    .hop5_fire (hop5_fire),
    .hop10_fire(hop10_fire),
    .busy      (busy),
    .fifo_full (fifo_full),
    .ovf_err   (ovf_err),
    .bad_code  (bad_code),
    .jam_err   (jam_err),
    .coins_paid(coins_paid)
  );

  always #5 clk = ~clk;

  // Pulse monitor, sampled on the falling edge.
  int   cyc = 0;
  int   n5_rise = 0, n10_rise = 0, n5_hi = 0, n10_hi = 0, both_hi = 0;
  logic p5 = 1'b0, p10 = 1'b0;
  int   rise_cyc[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (hop5_fire) n5_hi <= n5_hi + 1;
    if (hop10_fire) n10_hi <= n10_hi + 1;
    if (hop5_fire && hop10_fire) both_hi <= both_hi + 1;
    if (hop5_fire && !p5) begin
      n5_rise <= n5_rise + 1;
      rise_cyc.push_back(cyc);
    end
    if (hop10_fire && !p10) begin
      n10_rise <= n10_rise + 1;
      rise_cyc.push_back(cyc);
    end
    p5  <= hop5_fire;
    p10 <= hop10_fire;
  end

  logic [1:0] full_codes [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
  bit         exp_w10 [4]    = '{1'b0, 1'b1, 1'b0, 1'b0};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic apply_reset();
    change = 2'b00; coin_sense = 1'b0; clr_err = 1'b0;
    rst_n = 1'b0;
    ticks(2);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_fire_hi(output bit ok);
    int k = 0;
    while (!(hop5_fire || hop10_fire) && k < 200) begin tick(); k++; end
    ok = hop5_fire || hop10_fire;
  endtask

  task automatic wait_fire_lo(output bit ok);
    int k = 0;
    while ((hop5_fire || hop10_fire) && k < 200) begin tick(); k++; end
    ok = !(hop5_fire || hop10_fire);
  endtask

  // Wait for a pulse to finish, then report a coin (optionally with a new request).
  task automatic confirm_one(input bit push_en, input logic [1:0] code, output bit ok,
                             output bit was10);
    bit ok1, ok2;
    wait_fire_hi(ok1);
    was10 = hop10_fire;
    wait_fire_lo(ok2);
    coin_sense = 1'b1;
    if (push_en) change = code;
    tick();
    coin_sense = 1'b0;
    change = 2'b00;
    ok = ok1 && ok2;
  endtask

  task automatic test_reset();
    bit ok;
    int r10;
    rst_n = 1'b0;
    tick();
    checks++;
    if ({hop5_fire, hop10_fire, busy, fifo_full, ovf_err, bad_code, jam_err} !== 7'b0 ||
        coins_paid !== 8'd0) begin
      failures++;
      $display("FAIL reset_state: got flags=%b coins=%0d expected 0", {hop5_fire, hop10_fire,
               busy, fifo_full, ovf_err, bad_code, jam_err}, coins_paid);
    end
    rst_n = 1'b1;
    tick();
    change = 2'b10;
    tick();
    change = 2'b00;
    wait_fire_hi(ok);
    checks++;
    if (!ok || hop10_fire !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre_fire: got hop10=%b expected 1", hop10_fire);
    end
    ticks(2);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (hop10_fire !== 1'b0) begin
      failures++;
      $display("FAIL rst_fire_drop: got %b expected 0", hop10_fire);
    end
    checks++;
    if ({hop5_fire, busy, fifo_full, ovf_err, bad_code, jam_err} !== 6'b0 ||
        coins_paid !== 8'd0) begin
      failures++;
      $display("FAIL rst_mid_outputs: got flags=%b coins=%0d expected 0",
               {hop5_fire, busy, fifo_full, ovf_err, bad_code, jam_err}, coins_paid);
    end
    tick();
    rst_n = 1'b1;
    r10 = n10_rise;
    ticks(30);
    checks++;
    if (busy !== 1'b0 || n10_rise != r10) begin
      failures++;
      $display("FAIL rst_lost_request: got busy=%b new_pulses=%0d expected 0 0", busy,
               n10_rise - r10);
    end
  endtask

  task automatic test_single_payout();
    int b5, r5, r10;
    apply_reset();
    b5 = n5_hi; r5 = n5_rise; r10 = n10_rise;
    change = 2'b01;
    tick();
    checks++;
    if (hop5_fire !== 1'b0) begin
      failures++;
      $display("FAIL latency_early: got hop5=%b expected 0", hop5_fire);
    end
    tick();
    checks++;
    if (hop5_fire !== 1'b1) begin
      failures++;
      $display("FAIL latency_n2: got hop5=%b expected 1", hop5_fire);
    end
    tick();
    change = 2'b00;
    for (int k = 0; k < 20 && hop5_fire; k++) tick();
    ticks(10);
    coin_sense = 1'b1;
    tick();
    coin_sense = 1'b0;
    checks++;
    if (coins_paid !== 8'd1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_paid: got coins=%0d busy=%b expected 1 0", coins_paid, busy);
    end
    ticks(100);
    checks++;
    if (n5_hi - b5 != 8 || n5_rise - r5 != 1 || n10_rise != r10) begin
      failures++;
      $display("FAIL single_pulse: got hi=%0d rises5=%0d rises10=%0d expected 8 1 0",
               n5_hi - b5, n5_rise - r5, n10_rise - r10);
    end
  endtask

  task automatic test_timeout_jam();
    bit ok, w10;
    int base, r10;
    apply_reset();
    base = rise_cyc.size();
    r10 = n10_rise;
    change = 2'b10;
    ticks(2);
    change = 2'b00;
    ticks(240);
    checks++;
    if (n10_rise - r10 != 3 || rise_cyc.size() - base != 3) begin
      failures++;
      $display("FAIL jam_pulses: got %0d expected 3", n10_rise - r10);
    end else begin
      checks++;
      if (rise_cyc[base+1] - rise_cyc[base] != 72 || rise_cyc[base+2] - rise_cyc[base+1] != 72)
      begin
        failures++;
        $display("FAIL jam_spacing: got %0d,%0d expected 72,72",
                 rise_cyc[base+1] - rise_cyc[base], rise_cyc[base+2] - rise_cyc[base+1]);
      end
    end
    checks++;
    if (jam_err !== 1'b1 || busy !== 1'b1 || hop10_fire !== 1'b0) begin
      failures++;
      $display("FAIL jam_state: got jam=%b busy=%b fire=%b expected 1 1 0", jam_err, busy,
               hop10_fire);
    end
    ticks(100);
    checks++;
    if (n10_rise - r10 != 3) begin
      failures++;
      $display("FAIL jam_hold: got %0d pulses expected 3", n10_rise - r10);
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++;
    if (jam_err !== 1'b0) begin
      failures++;
      $display("FAIL jam_clear: got %b expected 0", jam_err);
    end
    confirm_one(1'b0, 2'b00, ok, w10);
    checks++;
    if (!ok || w10 !== 1'b1 || coins_paid !== 8'd1 || busy !== 1'b0 || n10_rise - r10 != 4)
    begin
      failures++;
      $display("FAIL jam_retry_paid: got ok=%b w10=%b coins=%0d busy=%b pulses=%0d expected 1 1 1 0 4",
               ok, w10, coins_paid, busy, n10_rise - r10);
    end
  endtask

  task automatic test_overflow();
    bit ok, w10;
    int r10;
    apply_reset();
    r10 = n10_rise;
    for (int i = 0; i < 5; i++) begin
      change = 2'b01;
      tick();
      change = 2'b00;
      if (i == 2) begin
        checks++;
        if (fifo_full !== 1'b0) begin
          failures++;
          $display("FAIL ovf_full_at3: got %b expected 0", fifo_full);
        end
      end
      if (i == 3) begin
        checks++;
        if (fifo_full !== 1'b1 || ovf_err !== 1'b0) begin
          failures++;
          $display("FAIL ovf_full_at4: got full=%b ovf=%b expected 1 0", fifo_full, ovf_err);
        end
      end
      tick();
    end
    checks++;
    if (ovf_err !== 1'b1 || fifo_full !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set: got ovf=%b full=%b expected 1 1", ovf_err, fifo_full);
    end
    for (int i = 0; i < 4; i++) begin
      confirm_one(1'b0, 2'b00, ok, w10);
      checks++;
      if (!ok || w10 !== 1'b0) begin
        failures++;
        $display("FAIL ovf_pay%0d: got ok=%b w10=%b expected 1 0", i, ok, w10);
      end
    end
    ticks(150);
    checks++;
    if (coins_paid !== 8'd4 || busy !== 1'b0 || fifo_full !== 1'b0 || n10_rise != r10) begin
      failures++;
      $display("FAIL ovf_total: got coins=%0d busy=%b full=%b expected 4 0 0", coins_paid,
               busy, fifo_full);
    end
  endtask

  task automatic test_illegal_edge();
    bit ok, w10;
    int r5, r10;
    apply_reset();
    r5 = n5_rise; r10 = n10_rise;
    change = 2'b11;
    ticks(3);
    change = 2'b00;
    tick();
    checks++;
    if (bad_code !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bad_set: got bad=%b busy=%b expected 1 0", bad_code, busy);
    end
    ticks(20);
    checks++;
    if (n5_rise != r5 || n10_rise != r10) begin
      failures++;
      $display("FAIL bad_nofire: got %0d pulses expected 0", n5_rise - r5 + n10_rise - r10);
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++;
    if (bad_code !== 1'b0) begin
      failures++;
      $display("FAIL bad_clear: got %b expected 0", bad_code);
    end
    change = 2'b11;
    clr_err = 1'b1;
    tick();
    change = 2'b00;
    clr_err = 1'b0;
    checks++;
    if (bad_code !== 1'b0) begin
      failures++;
      $display("FAIL clr_priority: got %b expected 0", bad_code);
    end
    tick();
    change = 2'b01;
    ticks(2);
    change = 2'b10;
    ticks(2);
    change = 2'b00;
    confirm_one(1'b0, 2'b00, ok, w10);
    ticks(150);
    checks++;
    if (!ok || w10 !== 1'b0 || n5_rise - r5 != 1 || n10_rise != r10 || coins_paid !== 8'd1 ||
        busy !== 1'b0) begin
      failures++;
      $display("FAIL direct_switch: got ok=%b p5=%0d p10=%0d coins=%0d expected 1 1 0 1", ok,
               n5_rise - r5, n10_rise - r10, coins_paid);
    end
  endtask

  task automatic test_fire_confirm();
    bit ok;
    int b10, r10;
    apply_reset();
    b10 = n10_hi; r10 = n10_rise;
    change = 2'b10;
    tick();
    change = 2'b00;
    wait_fire_hi(ok);
    tick();
    coin_sense = 1'b1;
    tick();
    coin_sense = 1'b0;
    wait_fire_lo(ok);
    checks++;
    if (!ok || coins_paid !== 8'd1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL fire_confirm: got coins=%0d busy=%b expected 1 0", coins_paid, busy);
    end
    ticks(100);
    checks++;
    if (n10_hi - b10 != 8 || n10_rise - r10 != 1) begin
      failures++;
      $display("FAIL fire_confirm_pulse: got hi=%0d rises=%0d expected 8 1", n10_hi - b10,
               n10_rise - r10);
    end
  endtask

  task automatic test_back_to_back();
    bit ok, w10, all_ok;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      change = full_codes[i];
      tick();
      change = 2'b00;
      tick();
    end
    checks++;
    if (fifo_full !== 1'b1) begin
      failures++;
      $display("FAIL b2b_full: got %b expected 1", fifo_full);
    end
    confirm_one(1'b1, 2'b01, ok, w10);
    checks++;
    if (!ok || w10 !== 1'b1 || fifo_full !== 1'b1 || ovf_err !== 1'b0 || coins_paid !== 8'd1)
    begin
      failures++;
      $display("FAIL b2b_simul: got ok=%b w10=%b full=%b ovf=%b coins=%0d expected 1 1 1 0 1",
               ok, w10, fifo_full, ovf_err, coins_paid);
    end
    for (int i = 0; i < 4; i++) begin
      confirm_one(1'b0, 2'b00, ok, w10);
      checks++;
      if (!ok || w10 !== exp_w10[i]) begin
        failures++;
        $display("FAIL b2b_order%0d: got ok=%b w10=%b expected 1 %b", i, ok, w10, exp_w10[i]);
      end
    end
    checks++;
    if (coins_paid !== 8'd5 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_total: got coins=%0d busy=%b expected 5 0", coins_paid, busy);
    end
    // Counter wrap over 256 payouts.
    apply_reset();
    all_ok = 1'b1;
    for (int i = 0; i < 256; i++) begin
      change = 2'b01;
      tick();
      change = 2'b00;
      confirm_one(1'b0, 2'b00, ok, w10);
      all_ok = all_ok && ok;
      if (i == 254) begin
        checks++;
        if (coins_paid !== 8'd255) begin
          failures++;
          $display("FAIL wrap_255: got %0d expected 255", coins_paid);
        end
      end
    end
    checks++;
    if (!all_ok || coins_paid !== 8'd0) begin
      failures++;
      $display("FAIL wrap_0: got ok=%b coins=%0d expected 1 0", all_ok, coins_paid);
    end
    checks++;
    if (both_hi != 0) begin
      failures++;
      $display("FAIL onehot: got %0d overlap cycles expected 0", both_hi);
    end
  endtask

  initial begin
    test_reset();
    test_single_payout();
    test_timeout_jam();
    test_overflow();
    test_illegal_edge();
    test_fire_confirm();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
